// File: rtl/sincpde_pkg.sv
// ---------------------------------------------------------------------------
// sincpde_pkg
// Shared definitions for the sincpde result capture slice.
//   SINCPDE_DATA_W    : default width of a core result word (signed, 48 bits)
//   SINCPDE_FRAME_LEN : default words per frame (7 divider + 6 IMAC results)
//   capState_t        : capture FSM states
//   fifoEntry_t       : one buffered word, {last, data}
//   entryLast/Data    : helpers to split a flat {last, data} FIFO word
// ---------------------------------------------------------------------------
package sincpde_pkg;

  localparam int SINCPDE_DATA_W    = 48;
  localparam int SINCPDE_FRAME_LEN = 13;

  typedef enum logic {
    IDLE    = 1'b0,
    CAPTURE = 1'b1
  } capState_t;

  typedef struct packed {
    logic                      last;
    logic [SINCPDE_DATA_W-1:0] data;
  } fifoEntry_t;

  // The FIFO stores {last, data} flat so it stays width generic; these
  // helpers keep the bit placement of the marker in one spot.
  function automatic logic entryLast(input logic [SINCPDE_DATA_W:0] entry);
    return entry[SINCPDE_DATA_W];
  endfunction

  function automatic logic [SINCPDE_DATA_W-1:0] entryData(input logic [SINCPDE_DATA_W:0] entry);
    return entry[SINCPDE_DATA_W-1:0];
  endfunction

endpackage

// File: rtl/sincpde_sync_fifo.sv
// ---------------------------------------------------------------------------
// sincpde_sync_fifo
// Single clock FIFO with synchronous active-high reset. Occupancy is tracked
// with read/write pointers carrying one extra wrap bit, so full and empty are
// both derived from registered state only. The head entry is read
// combinationally, which makes a word written at one edge visible right after
// that edge.
//
// Ports:
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset (empties the FIFO)
//   i_wrEn     : write request; ignored while o_full is high
//   i_wrData   : write data
//   i_rdEn     : read request; ignored while o_empty is high
//   o_rdData   : head entry, forced to zero while empty
//   o_full     : all DEPTH entries are occupied
//   o_empty    : no entry is stored
// ---------------------------------------------------------------------------
module sincpde_sync_fifo #(
  parameter int WIDTH = 49,
  parameter int DEPTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_wrEn,
  input  logic [WIDTH-1:0] i_wrData,
  input  logic             i_rdEn,
  output logic [WIDTH-1:0] o_rdData,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wrPtr;
  logic [AW:0]      r_rdPtr;

  logic w_full;
  logic w_empty;
  logic w_doWrite;
  logic w_doRead;

  // Same index with opposite wrap bits means the writer is a full lap ahead.
  assign w_full  = (r_wrPtr[AW] != r_rdPtr[AW]) &&
                   (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]);
  assign w_empty = (r_wrPtr == r_rdPtr);

  // Full is judged on the start-of-cycle occupancy, so a write into a full
  // FIFO is dropped even when a read frees a slot in the same cycle.
  assign w_doWrite = i_wrEn && !w_full;
  assign w_doRead  = i_rdEn && !w_empty;

  // Pointer update; a simultaneous read and write leaves occupancy unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
    end else begin
      if (w_doWrite) begin
        r_wrPtr <= r_wrPtr + (AW+1)'(1);
      end
      if (w_doRead) begin
        r_rdPtr <= r_rdPtr + (AW+1)'(1);
      end
    end
  end

  // Storage is not reset; stale contents are never visible because the
  // read port is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (w_doWrite) begin
      r_mem[r_wrPtr[AW-1:0]] <= i_wrData;
    end
  end

  assign o_rdData = w_empty ? '0 : r_mem[r_rdPtr[AW-1:0]];
  assign o_full   = w_full;
  assign o_empty  = w_empty;

endmodule

// File: rtl/sincpde_result_capture.sv
// ---------------------------------------------------------------------------
// sincpde_result_capture
// Captures a fixed-length burst of sincpde core result words on every sync
// pulse, buffers them as {last, data} in a FIFO and streams them out over a
// valid/ready interface with a last-word marker. Also keeps a frame counter
// and sticky overflow / framing error flags.
//
// Optional build macro: SINCPDE_CAPTURE_CHECKSUM_EN adds the `checksum`
// output, the modulo 2^DATA_W sum of every word of the last completed frame.
//
// Ports:
//   clk         : clock, rising edge
//   rst         : synchronous active-high reset
//   sync_in     : frame start from the core's sync_out
//   in_data     : result word, valid on the sync cycle and FRAME_LEN-1 after
//   m_valid     : output word available
//   m_ready     : consumer accepts the word when m_valid && m_ready
//   m_data      : output word
//   m_last      : final word of a frame
//   frame_count : frames completed, wraps modulo 2^CNT_W
//   busy        : high while a frame is being captured
//   overflow    : sticky, a word was dropped because the FIFO was full
//   frame_err   : sticky, sync_in arrived during a capture
//   checksum    : (optional) sum of the last completed frame
// ---------------------------------------------------------------------------
module sincpde_result_capture
  import sincpde_pkg::*;
#(
  parameter int DATA_W    = SINCPDE_DATA_W,
  parameter int FRAME_LEN = SINCPDE_FRAME_LEN,
  parameter int DEPTH     = 32,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sync_in,
  input  logic [DATA_W-1:0] in_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic [CNT_W-1:0]  frame_count,
  output logic              busy,
  output logic              overflow,
  output logic              frame_err
`ifdef SINCPDE_CAPTURE_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] checksum
`endif
);

  localparam int IDX_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

  capState_t          r_state;
  logic [IDX_W-1:0]   r_wordIdx;
  logic [CNT_W-1:0]   r_frameCount;
  logic               r_overflow;
  logic               r_frameErr;

  logic               w_wrEn;
  logic               w_wrLast;
  logic               w_isLastIdx;
  logic [DATA_W:0]    w_wrEntry;
  logic [DATA_W:0]    w_rdEntry;
  logic               w_fifoFull;
  logic               w_fifoEmpty;

  // A word is captured on the sync cycle out of IDLE and on every cycle of
  // CAPTURE; a sync pulse during CAPTURE does not restart the frame.
  assign w_isLastIdx = (r_wordIdx == IDX_W'(FRAME_LEN - 1));
  assign w_wrEn      = ((r_state == IDLE) && sync_in) || (r_state == CAPTURE);
  assign w_wrLast    = (r_state == IDLE) ? (FRAME_LEN == 1) : w_isLastIdx;
  assign w_wrEntry   = {w_wrLast, in_data};

  // Framing FSM plus the counters and sticky flags that follow it. The word
  // index advances whether or not the FIFO accepted the write, so a dropped
  // word never shifts the position of later words within the frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_wordIdx    <= '0;
      r_frameCount <= '0;
      r_overflow   <= 1'b0;
      r_frameErr   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (sync_in && (FRAME_LEN > 1)) begin
            r_wordIdx <= IDX_W'(1);
            r_state   <= CAPTURE;
          end
        end
        CAPTURE: begin
          if (sync_in) begin
            r_frameErr <= 1'b1;
          end
          if (w_isLastIdx) begin
            r_wordIdx <= '0;
            r_state   <= IDLE;
          end else begin
            r_wordIdx <= r_wordIdx + IDX_W'(1);
          end
        end
        default: begin
          r_wordIdx <= '0;
          r_state   <= IDLE;
        end
      endcase

      // frame_count counts frames that ended, intact or not.
      if (w_wrEn && w_wrLast) begin
        r_frameCount <= r_frameCount + CNT_W'(1);
      end

      if (w_wrEn && w_fifoFull) begin
        r_overflow <= 1'b1;
      end
    end
  end

`ifdef SINCPDE_CAPTURE_CHECKSUM_EN
  logic [DATA_W-1:0] r_accum;
  logic [DATA_W-1:0] r_checksum;
  logic [DATA_W-1:0] w_accumNext;

  // Word 0 restarts the sum, so no separate clear cycle is needed between
  // back-to-back frames.
  assign w_accumNext = (r_state == IDLE) ? in_data : (r_accum + in_data);

  // Running sum over every captured word, dropped ones included; the total
  // is published on the same edge that bumps frame_count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_accum    <= '0;
      r_checksum <= '0;
    end else begin
      if (w_wrEn) begin
        r_accum <= w_accumNext;
      end
      if (w_wrEn && w_wrLast) begin
        r_checksum <= w_accumNext;
      end
    end
  end

  assign checksum = r_checksum;
`endif

  sincpde_sync_fifo #(
    .WIDTH (DATA_W + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .i_wrEn   (w_wrEn),
    .i_wrData (w_wrEntry),
    .i_rdEn   (m_ready),
    .o_rdData (w_rdEntry),
    .o_full   (w_fifoFull),
    .o_empty  (w_fifoEmpty)
  );

  assign m_valid     = !w_fifoEmpty;
  assign m_data      = w_rdEntry[DATA_W-1:0];
  assign m_last      = w_rdEntry[DATA_W];
  assign frame_count = r_frameCount;
  assign busy        = (r_state == CAPTURE);
  assign overflow    = r_overflow;
  assign frame_err   = r_frameErr;

endmodule
